// File: rtl/slink_bist_ctrl.sv
// S-Link RX BIST sequencer: clears the checker, waits for lock, runs N packets, reports pass/fail.
// Optional build macro SLINK_BIST_CTRL_RETRY_EN adds automatic retry of lock/unrecoverable failures.
module slink_bist_ctrl #(
  parameter int RST_CYCLES  = 4,
  parameter int TIMER_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   swi_start,
  input  logic                   swi_abort,
  input  logic [TIMER_WIDTH-1:0] swi_lock_timeout,
  input  logic [15:0]            swi_run_pkts,
  input  logic [15:0]            swi_err_thresh,
  input  logic                   bist_locked,
  input  logic                   bist_unrec,
  input  logic [15:0]            bist_errors,
  input  logic                   rx_sop,
`ifdef SLINK_BIST_CTRL_RETRY_EN
  input  logic [3:0]             swi_retries,
  output logic [3:0]             retry_count,
`endif
  output logic                   bist_en,
  output logic                   bist_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [1:0]             fail_code,
  output logic [15:0]            pkt_count,
  output logic [15:0]            err_snapshot
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOCK_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] CLR_LAST = TIMER_WIDTH'(RST_CYCLES - 1);

  state_t                 state, state_d;
  logic [TIMER_WIDTH-1:0] timer, timer_d, timer_inc;
  logic                   bist_en_d, bist_reset_d, busy_d, done_d, pass_d;
  logic [1:0]             fail_code_d, code_n;
  logic [15:0]            pkt_count_d, err_snapshot_d, pkt_next;
  logic                   start_clr, go_fail, go_pass, finish;
`ifdef SLINK_BIST_CTRL_RETRY_EN
  logic [3:0]             retry_d;
  logic                   retry_ok;
`endif

  assign timer_inc = (&timer) ? timer : timer + 1'b1;
  assign pkt_next  = (rx_sop && !(&pkt_count)) ? pkt_count + 16'd1 : pkt_count;

  always_comb begin
    state_d        = state;
    timer_d        = timer;
    bist_en_d      = bist_en;
    bist_reset_d   = bist_reset;
    done_d         = done;
    pass_d         = pass;
    fail_code_d    = fail_code;
    pkt_count_d    = pkt_count;
    err_snapshot_d = err_snapshot;
    start_clr      = 1'b0;
    go_fail        = 1'b0;
    go_pass        = 1'b0;
    code_n         = 2'd0;
`ifdef SLINK_BIST_CTRL_RETRY_EN
    retry_d        = retry_count;
    retry_ok       = 1'b0;
`endif

    case (state)
      S_IDLE, S_DONE: start_clr = swi_start;
      S_CLR: begin
        if (timer == CLR_LAST) begin
          state_d      = S_LOCK_WAIT;
          bist_reset_d = 1'b0;
          timer_d      = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_LOCK_WAIT: begin
        timer_d = timer_inc;
        // Compare the incremented value so a limit of N leaves exactly N cycles in this state.
        if (bist_unrec) begin
          go_fail = 1'b1;
          code_n  = 2'd2;
        end else if (bist_locked) begin
          state_d = S_RUN;
        end else if ((swi_lock_timeout != '0) && (timer_inc == swi_lock_timeout)) begin
          go_fail = 1'b1;
          code_n  = 2'd1;
        end
      end
      S_RUN: begin
        pkt_count_d = pkt_next;
        if (bist_unrec || !bist_locked) begin
          go_fail = 1'b1;
          code_n  = 2'd2;
        end else if (bist_errors > swi_err_thresh) begin
          go_fail = 1'b1;
          code_n  = 2'd3;
        end else if (pkt_next >= swi_run_pkts) begin
          go_pass = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SLINK_BIST_CTRL_RETRY_EN
    retry_ok = go_fail && (code_n != 2'd3) && (retry_count < swi_retries);
    finish   = (go_fail || go_pass) && !retry_ok;
    if (retry_ok) begin
      state_d      = S_CLR;
      bist_en_d    = 1'b1;
      bist_reset_d = 1'b1;
      timer_d      = '0;
      pkt_count_d  = '0;
      retry_d      = retry_count + 4'd1;
    end
`else
    finish = go_fail || go_pass;
`endif

    if (finish) begin
      state_d        = S_DONE;
      bist_en_d      = 1'b0;
      bist_reset_d   = 1'b0;
      done_d         = 1'b1;
      pass_d         = go_pass;
      fail_code_d    = code_n;
      err_snapshot_d = bist_errors;
    end

    if (start_clr) begin
      state_d        = S_CLR;
      bist_en_d      = 1'b1;
      bist_reset_d   = 1'b1;
      timer_d        = '0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
      fail_code_d    = 2'd0;
      pkt_count_d    = '0;
      err_snapshot_d = '0;
`ifdef SLINK_BIST_CTRL_RETRY_EN
      retry_d        = '0;
`endif
    end

    // Abort overrides everything, including a simultaneous start; pkt_count is kept for debug.
    if (swi_abort) begin
      state_d      = S_IDLE;
      bist_en_d    = 1'b0;
      bist_reset_d = 1'b0;
      timer_d      = '0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      fail_code_d  = 2'd0;
`ifdef SLINK_BIST_CTRL_RETRY_EN
      retry_d      = '0;
`endif
    end

    busy_d = (state_d == S_CLR) || (state_d == S_LOCK_WAIT) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      bist_en      <= 1'b0;
      bist_reset   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_code    <= 2'd0;
      pkt_count    <= '0;
      err_snapshot <= '0;
`ifdef SLINK_BIST_CTRL_RETRY_EN
      retry_count  <= '0;
`endif
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      bist_en      <= bist_en_d;
      bist_reset   <= bist_reset_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      fail_code    <= fail_code_d;
      pkt_count    <= pkt_count_d;
      err_snapshot <= err_snapshot_d;
`ifdef SLINK_BIST_CTRL_RETRY_EN
      retry_count  <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_slink_bist_ctrl.sv
// Self-checking bench for slink_bist_ctrl; final results are predicted into exp_q when a run is
// launched and popped when done rises. Retry scenario builds only with SLINK_BIST_CTRL_RETRY_EN.
module tb_slink_bist_ctrl;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          swi_start, swi_abort;
  logic [TW-1:0] swi_lock_timeout;
  logic [15:0]   swi_run_pkts, swi_err_thresh;
  logic          bist_locked, bist_unrec;
  logic [15:0]   bist_errors;
  logic          rx_sop;
  logic          bist_en, bist_reset, busy, done, pass;
  logic [1:0]    fail_code;
  logic [15:0]   pkt_count, err_snapshot;
`ifdef SLINK_BIST_CTRL_RETRY_EN
  logic [3:0]    swi_retries, retry_count;
`endif

  int            n_cmp  = 0;
  int            n_fail = 0;
  // {pass, fail_code, pkt_count, err_snapshot}
  logic [34:0]   exp_q[$];
  logic [34:0]   exp_v, got_v;

  slink_bist_ctrl #(.RST_CYCLES(4), .TIMER_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .swi_start(swi_start), .swi_abort(swi_abort),
    .swi_lock_timeout(swi_lock_timeout), .swi_run_pkts(swi_run_pkts),
    .swi_err_thresh(swi_err_thresh), .bist_locked(bist_locked),
    .bist_unrec(bist_unrec), .bist_errors(bist_errors), .rx_sop(rx_sop),
`ifdef SLINK_BIST_CTRL_RETRY_EN
    .swi_retries(swi_retries), .retry_count(retry_count),
`endif
    .bist_en(bist_en), .bist_reset(bist_reset), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .pkt_count(pkt_count),
    .err_snapshot(err_snapshot)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    swi_start = 1'b1;
    tick();
    swi_start = 1'b0;
  endtask

  task automatic pulse_abort();
    swi_abort = 1'b1;
    tick();
    swi_abort = 1'b0;
  endtask

  task automatic wait_clr_exit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!bist_reset) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bist_en, bist_reset, busy, done, pass, fail_code, pkt_count, err_snapshot} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b rst=%b busy=%b done=%b pass=%b code=%0d pkts=%0d snap=%0d, expected all 0",
               bist_en, bist_reset, busy, done, pass, fail_code, pkt_count, err_snapshot);
    end
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({bist_en, bist_reset, busy, done} !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b rst=%b busy=%b done=%b, expected 0000",
               bist_en, bist_reset, busy, done);
    end
  endtask

  task automatic test_pass_run();
    int cnt;
    bit ok;
    swi_lock_timeout = '0;
    swi_run_pkts     = 16'd8;
    swi_err_thresh   = 16'd0;
    bist_errors      = 16'd0;
    bist_locked      = 1'b0;
    exp_q.push_back({1'b1, 2'd0, 16'd8, 16'd0});
    pulse_start();
    n_cmp++;
    if (!(bist_en === 1'b1 && busy === 1'b1)) begin
      n_fail++;
      $display("FAIL clr_entry: got en=%b busy=%b, expected 1 1", bist_en, busy);
    end
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!bist_reset) break;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL clr_length: bist_reset high %0d cycles, expected 4", cnt);
    end
    repeat (10) tick();
    bist_locked = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      rx_sop = 1'b1;
      tick();
      rx_sop = 1'b0;
      if (k == 6) begin
        n_cmp++;
        if (done !== 1'b0 || bist_en !== 1'b1) begin
          n_fail++;
          $display("FAIL run_not_early: got done=%b en=%b after 7 SOPs, expected 0 1", done, bist_en);
        end
      end
      if (k < 7) repeat ($urandom_range(0, 2)) tick();
    end
    wait_done(1, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pass_done: done=%b after 8th SOP, expected 1", done);
    end
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (got_v !== exp_v || bist_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_result: got %h en=%b busy=%b, expected %h en=0 busy=0", got_v, bist_en, busy, exp_v);
    end
  endtask

  task automatic test_lock_timeout();
    int n;
    bit ok;
    swi_lock_timeout = TW'(100);
    bist_locked      = 1'b0;
    bist_errors      = 16'h0033;
    exp_q.push_back({1'b0, 2'd1, 16'd0, 16'h0033});
    pulse_start();
    wait_clr_exit(ok);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      tick();
      n++;
    end
    n_cmp++;
    if (!ok || n != 100) begin
      n_fail++;
      $display("FAIL lock_timeout_len: DONE %0d cycles after LOCK_WAIT entry (clr_ok=%b), expected 100", n, ok);
    end
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (got_v !== exp_v || bist_en !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_timeout_result: got %h en=%b done=%b, expected %h en=0 done=1", got_v, bist_en, done, exp_v);
    end
    bist_errors = 16'd0;
  endtask

  task automatic test_err_thresh();
    bit ok;
    swi_lock_timeout = '0;
    swi_run_pkts     = 16'd100;
    swi_err_thresh   = 16'd5;
    bist_errors      = 16'd5;
    bist_locked      = 1'b1;
    exp_q.push_back({1'b0, 2'd3, 16'd3, 16'd6});
    pulse_start();
    wait_clr_exit(ok);
    tick();
    repeat (3) begin
      rx_sop = 1'b1;
      tick();
      rx_sop = 1'b0;
    end
    n_cmp++;
    if (done !== 1'b0 || !ok) begin
      n_fail++;
      $display("FAIL thresh_equal: done=%b with errors==thresh (clr_ok=%b), expected 0", done, ok);
    end
    bist_errors = 16'd6;
    tick();
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL thresh_exceed: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    bist_errors = 16'd0;
  endtask

  task automatic test_priority();
    bit ok;
    swi_run_pkts   = 16'd100;
    swi_err_thresh = 16'd5;
    bist_locked    = 1'b1;
    // unrecoverable outranks error threshold
    exp_q.push_back({1'b0, 2'd2, 16'd1, 16'd9});
    pulse_start();
    wait_clr_exit(ok);
    tick();
    rx_sop = 1'b1;
    tick();
    rx_sop      = 1'b0;
    bist_unrec  = 1'b1;
    bist_errors = 16'd9;
    tick();
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL prio_unrec_vs_err: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    bist_unrec  = 1'b0;
    bist_errors = 16'd2;
    // lock lost alone
    exp_q.push_back({1'b0, 2'd2, 16'd0, 16'd2});
    pulse_start();
    wait_clr_exit(ok);
    tick();
    bist_locked = 1'b0;
    tick();
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL lock_lost: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    // unrecoverable while still waiting for lock
    swi_lock_timeout = '0;
    exp_q.push_back({1'b0, 2'd2, 16'd0, 16'd2});
    pulse_start();
    wait_clr_exit(ok);
    repeat (2) tick();
    bist_unrec = 1'b1;
    tick();
    bist_unrec = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL unrec_in_lock_wait: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    bist_errors = 16'd0;
  endtask

  task automatic test_run_pkts_zero();
    bit ok;
    swi_run_pkts   = 16'd0;
    swi_err_thresh = 16'd5;
    bist_errors    = 16'd3;
    bist_locked    = 1'b1;
    exp_q.push_back({1'b1, 2'd0, 16'd0, 16'd3});
    pulse_start();
    wait_clr_exit(ok);
    tick();
    tick();
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL run_pkts_zero: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    bist_errors = 16'd0;
  endtask

  task automatic test_abort();
    bit ok;
    int cnt;
    // start and abort together from DONE: abort wins
    swi_start = 1'b1;
    swi_abort = 1'b1;
    tick();
    swi_start = 1'b0;
    swi_abort = 1'b0;
    n_cmp++;
    if ({done, busy, bist_en, bist_reset, pass, fail_code} !== 7'd0) begin
      n_fail++;
      $display("FAIL start_abort_same: got done=%b busy=%b en=%b rst=%b pass=%b code=%0d, expected all 0",
               done, busy, bist_en, bist_reset, pass, fail_code);
    end
    // abort mid-RUN keeps pkt_count
    swi_run_pkts   = 16'd100;
    swi_err_thresh = 16'd5;
    bist_locked    = 1'b1;
    pulse_start();
    wait_clr_exit(ok);
    tick();
    repeat (2) begin
      rx_sop = 1'b1;
      tick();
      rx_sop = 1'b0;
    end
    pulse_abort();
    n_cmp++;
    if (bist_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_run: got en=%b busy=%b done=%b pkts=%0d, expected 0 0 0 2",
               bist_en, busy, done, pkt_count);
    end
    // start during CLR must not stretch the checker reset
    bist_locked = 1'b0;
    swi_lock_timeout = '0;
    swi_start = 1'b1;
    tick();
    swi_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bist_reset) break;
      cnt++;
      swi_start = (i == 1);
      tick();
    end
    swi_start = 1'b0;
    n_cmp++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL start_in_clr: bist_reset high %0d cycles, expected 4", cnt);
    end
    repeat (3) tick();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || bist_reset !== 1'b0 || bist_en !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_lock_wait: got busy=%b rst=%b en=%b, expected 1 0 1", busy, bist_reset, bist_en);
    end
    pulse_abort();
  endtask

`ifdef SLINK_BIST_CTRL_RETRY_EN
  task automatic test_retry();
    int  n_clr;
    bit  prev;
    swi_retries      = 4'd2;
    swi_lock_timeout = TW'(20);
    bist_locked      = 1'b0;
    bist_errors      = 16'd0;
    exp_q.push_back({1'b0, 2'd1, 16'd0, 16'd0});
    pulse_start();
    n_clr = 1;
    prev  = bist_reset;
    for (int i = 0; i < 1000; i++) begin
      if (done) break;
      tick();
      if (bist_reset && !prev) n_clr++;
      prev = bist_reset;
    end
    n_cmp++;
    if (n_clr != 3 || retry_count !== 4'd2) begin
      n_fail++;
      $display("FAIL retry_count: CLR entered %0d times, retry_count=%0d, expected 3 and 2", n_clr, retry_count);
    end
    exp_v = exp_q.pop_front();
    got_v = {pass, fail_code, pkt_count, err_snapshot};
    n_cmp++;
    if (done !== 1'b1 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL retry_result: got done=%b %h, expected done=1 %h", done, got_v, exp_v);
    end
    swi_retries = 4'd0;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    reset            = 1'b1;
    swi_start        = 1'b0;
    swi_abort        = 1'b0;
    swi_lock_timeout = '0;
    swi_run_pkts     = 16'd0;
    swi_err_thresh   = 16'd0;
    bist_locked      = 1'b0;
    bist_unrec       = 1'b0;
    bist_errors      = 16'd0;
    rx_sop           = 1'b0;
`ifdef SLINK_BIST_CTRL_RETRY_EN
    swi_retries      = 4'd0;
`endif
    test_reset();
    test_pass_run();
    test_lock_timeout();
    test_err_thresh();
    test_priority();
    test_run_pkts_zero();
    test_abort();
`ifdef SLINK_BIST_CTRL_RETRY_EN
    test_retry();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
